snitch_fp_dispatch: RTL and testbench

- Parametrised successor to the single-FPU subsystem front-end.
- Accepts decoded accelerator requests on one valid/ready port and dispatches them round-robin to NumUnits replicated, internally in-order FP execution units.
- Returns each unit's result on the accelerator response port strictly in issue order, tracked by an issue-order FIFO.
- Sits between the core's accelerator interconnect (or FPU sequencer) and the FPU instances.

---
 rtl/snitch_fp_dispatch_pkg.sv | 18 +
 rtl/snitch_fp_dispatch_if.sv | 25 ++
 rtl/snitch_fp_dispatch_fifo.sv | 50 +++++
 rtl/snitch_fp_dispatch.sv | 129 ++++++++++++
 tb/tb_snitch_fp_dispatch.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/snitch_fp_dispatch_pkg.sv
// rtl/snitch_fp_dispatch_pkg.sv - shared types and helpers for the FP dispatch front-end
package snitch_fp_dispatch_pkg;

  localparam int unsigned MaxUnits        = 8;
  localparam int unsigned MaxUnitIdxWidth = 3;
  localparam int unsigned MaxIdWidth      = 16;

  // One issue-order record: which unit got the op and which id it must answer with.
  typedef struct packed {
    logic [MaxUnitIdxWidth-1:0] unit;
    logic [MaxIdWidth-1:0]      id;
  } order_entry_t;

  function automatic int unsigned unit_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snitch_fp_dispatch_if.sv
// rtl/snitch_fp_dispatch_if.sv - accelerator request/response port bundle
interface snitch_fp_dispatch_if #(
  parameter int unsigned FLEN    = 64,
  parameter int unsigned IdWidth = 5
);
  logic [IdWidth-1:0]  req_id;
  logic [31:0]         req_op;
  logic [3*FLEN-1:0]   req_args;
  logic                req_valid;
  logic                req_ready;
  logic [IdWidth-1:0]  resp_id;
  logic [FLEN-1:0]     resp_data;
  logic                resp_valid;
  logic                resp_ready;

  modport master (
    output req_id, req_op, req_args, req_valid, resp_ready,
    input  req_ready, resp_id, resp_data, resp_valid
  );

  modport slave (
    input  req_id, req_op, req_args, req_valid, resp_ready,
    output req_ready, resp_id, resp_data, resp_valid
  );
endinterface

// File: rtl/snitch_fp_dispatch_fifo.sv
// rtl/snitch_fp_dispatch_fifo.sv - non-fall-through order FIFO with occupancy count
module snitch_fp_dispatch_fifo #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 4,
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntWidth = $clog2(Depth) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [CntWidth-1:0]  usage_o
);
  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrWidth-1:0]  wr_q, rd_q;
  logic [CntWidth-1:0]  cnt_q;
  logic                 do_push, do_pop;

  assign full_o  = (cnt_q == CntWidth'(Depth));
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrWidth'(1);
      if (do_pop)  rd_q <= rd_q + PtrWidth'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntWidth'(1);
        2'b01:   cnt_q <= cnt_q - CntWidth'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/snitch_fp_dispatch.sv
// rtl/snitch_fp_dispatch.sv - round-robin dispatch to replicated FP units, in-order results
module snitch_fp_dispatch
  import snitch_fp_dispatch_pkg::*;
#(
  parameter int unsigned NumUnits = 2,
  parameter int unsigned Depth    = 4,
  parameter int unsigned FLEN     = 64,
  parameter int unsigned IdWidth  = 5,
  localparam int unsigned UnitIdxWidth = unit_idx_width(NumUnits),
  localparam int unsigned CntWidth     = $clog2(Depth) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  snitch_fp_dispatch_if.slave      acc,
  output logic [31:0]              unit_req_op_o,
  output logic [3*FLEN-1:0]        unit_req_args_o,
  output logic [NumUnits-1:0]      unit_req_valid_o,
  input  logic [NumUnits-1:0]      unit_req_ready_i,
  input  logic [NumUnits*FLEN-1:0] unit_resp_data_i,
  input  logic [NumUnits-1:0]      unit_resp_valid_i,
  output logic [NumUnits-1:0]      unit_resp_ready_o,
  output logic [CntWidth-1:0]      outstanding_o,
  output logic                     issue_o,
  output logic                     stall_o
);
  logic [UnitIdxWidth-1:0] rr_q, sel, hu;
  logic [UnitIdxWidth:0]   cand, rr_nxt;
  logic                    any_ready, full, empty, push, pop;
  logic                    issue_q, stall_q;
  order_entry_t            push_entry, head;
  logic [CntWidth-1:0]     pend_q [NumUnits];

  // First ready unit at or after rr_q, wrapping modulo NumUnits.
  always_comb begin
    sel       = '0;
    any_ready = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NumUnits; i++) begin
      cand = {1'b0, rr_q} + (UnitIdxWidth+1)'(i);
      if (cand >= (UnitIdxWidth+1)'(NumUnits)) cand = cand - (UnitIdxWidth+1)'(NumUnits);
      if (!any_ready && unit_req_ready_i[cand[UnitIdxWidth-1:0]]) begin
        sel       = cand[UnitIdxWidth-1:0];
        any_ready = 1'b1;
      end
    end
    rr_nxt = {1'b0, sel} + (UnitIdxWidth+1)'(1);
    if (rr_nxt >= (UnitIdxWidth+1)'(NumUnits)) rr_nxt = '0;
  end

  assign acc.req_ready   = any_ready & ~full;
  assign push            = acc.req_valid & acc.req_ready;
  assign unit_req_op_o   = acc.req_op;
  assign unit_req_args_o = acc.req_args;

  always_comb begin
    unit_req_valid_o = '0;
    if (any_ready) unit_req_valid_o[sel] = acc.req_valid & ~full;
  end

  always_comb begin
    push_entry      = '0;
    push_entry.unit = MaxUnitIdxWidth'(sel);
    push_entry.id   = MaxIdWidth'(acc.req_id);
  end

  snitch_fp_dispatch_fifo #(
    .DataWidth ($bits(order_entry_t)),
    .Depth     (Depth)
  ) i_order_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .usage_o (outstanding_o)
  );

  // Only the head unit may hand over its result; the rest are held back.
  assign hu             = head.unit[UnitIdxWidth-1:0];
  assign acc.resp_valid = ~empty & unit_resp_valid_i[hu];
  assign acc.resp_data  = unit_resp_data_i[hu*FLEN +: FLEN];
  assign acc.resp_id    = head.id[IdWidth-1:0];
  assign pop            = acc.resp_valid & acc.resp_ready;

  always_comb begin
    unit_resp_ready_o     = '0;
    unit_resp_ready_o[hu] = ~empty & acc.resp_ready;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q    <= '0;
      issue_q <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      if (push) rr_q <= rr_nxt[UnitIdxWidth-1:0];
      issue_q <= push;
      stall_q <= acc.req_valid & ~acc.req_ready;
    end
  end

  assign issue_o = issue_q;
  assign stall_o = stall_q;

  // Per-unit count of queued entries, used to flag results nobody asked for.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned u = 0; u < NumUnits; u++) pend_q[u] <= '0;
    end else begin
      for (int unsigned u = 0; u < NumUnits; u++) begin
        pend_q[u] <= pend_q[u]
                   + CntWidth'(push && (sel == UnitIdxWidth'(u)))
                   - CntWidth'(pop && (hu == UnitIdxWidth'(u)));
      end
    end
  end

  for (genvar u = 0; u < NumUnits; u++) begin : g_orphan_chk
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      unit_resp_valid_i[u] |-> (pend_q[u] != '0));
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (acc.resp_valid && !acc.resp_ready) |=>
      (acc.resp_valid && $stable(acc.resp_id) && $stable(acc.resp_data)));
endmodule

// File: tb/tb_snitch_fp_dispatch.sv
// tb/tb_snitch_fp_dispatch.sv - directed self-checking bench for snitch_fp_dispatch
module tb_snitch_fp_dispatch;
  localparam int NU = 2, DEP = 4, FL = 64, IW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   unit_req_op;
  logic [3*FL-1:0] unit_req_args;
  logic [NU-1:0] unit_req_valid, unit_req_ready, unit_resp_valid, unit_resp_ready;
  logic [NU*FL-1:0] unit_resp_data;
  logic [2:0]    outstanding;
  logic          issue, stall;
  int            total = 0, bad = 0;

  always #5 clk = ~clk;

  snitch_fp_dispatch_if #(.FLEN(FL), .IdWidth(IW)) acc ();

  snitch_fp_dispatch #(.NumUnits(NU), .Depth(DEP), .FLEN(FL), .IdWidth(IW)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .acc               (acc),
    .unit_req_op_o     (unit_req_op),
    .unit_req_args_o   (unit_req_args),
    .unit_req_valid_o  (unit_req_valid),
    .unit_req_ready_i  (unit_req_ready),
    .unit_resp_data_i  (unit_resp_data),
    .unit_resp_valid_i (unit_resp_valid),
    .unit_resp_ready_o (unit_resp_ready),
    .outstanding_o     (outstanding),
    .issue_o           (issue),
    .stall_o           (stall)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue_req(input logic [IW-1:0] id, input logic [NU-1:0] exp_valid);
    acc.req_valid = 1'b1;
    acc.req_id    = id;
    settle();
    chk("req_ready", acc.req_ready, 1'b1);
    chk("unit_req_valid", unit_req_valid, exp_valid);
    step();
    acc.req_valid = 1'b0;
  endtask

  task automatic drain_one(input int unit, input logic [IW-1:0] id, input logic [FL-1:0] data);
    unit_resp_valid = '0;
    unit_resp_valid[unit] = 1'b1;
    unit_resp_data[unit*FL +: FL] = data;
    acc.resp_ready = 1'b1;
    settle();
    chk("resp_valid", acc.resp_valid, 1'b1);
    chk("resp_id", acc.resp_id, id);
    chk("resp_data", acc.resp_data, data);
    chk("unit_resp_ready", unit_resp_ready, 64'(1) << unit);
    step();
    unit_resp_valid = '0;
    acc.resp_ready  = 1'b0;
  endtask

  initial begin
    acc.req_valid   = 1'b0;
    acc.req_id      = '0;
    acc.req_op      = '0;
    acc.req_args    = '0;
    acc.resp_ready  = 1'b1;
    unit_req_ready  = '0;
    unit_resp_valid = '0;
    unit_resp_data  = '0;
    step();
    step();
    chk("rst_outstanding", outstanding, 3'd0);
    chk("rst_issue", issue, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_resp_valid", acc.resp_valid, 1'b0);
    chk("rst_unit_resp_ready", unit_resp_ready, 2'b00);
    rst_n = 1'b1;
    acc.resp_ready = 1'b0;
    step();

    // round-robin over both ready units, results in issue order
    unit_req_ready = 2'b11;
    acc.req_op     = 32'hDEAD_BEEF;
    acc.req_args   = {64'h3333, 64'h2222, 64'h1111};
    settle();
    chk("op_pass", unit_req_op, 32'hDEAD_BEEF);
    chk("args_pass_b", unit_req_args[127:64], 64'h2222);
    issue_req(5'd1, 2'b01);
    issue_req(5'd2, 2'b10);
    issue_req(5'd3, 2'b01);
    issue_req(5'd4, 2'b10);
    chk("rr_issue", issue, 1'b1);
    chk("rr_outstanding", outstanding, 3'd4);
    chk("rr_stall", stall, 1'b0);
    drain_one(0, 5'd1, 64'hA1);
    drain_one(1, 5'd2, 64'hB2);
    drain_one(0, 5'd3, 64'hA3);
    drain_one(1, 5'd4, 64'hB4);
    chk("rr_drained", outstanding, 3'd0);

    // unit 1 finishes first but must wait behind unit 0
    issue_req(5'd1, 2'b01);
    issue_req(5'd2, 2'b10);
    unit_resp_valid = 2'b10;
    unit_resp_data[127:64] = 64'hB;
    acc.resp_ready = 1'b1;
    settle();
    chk("ooo_resp_valid", acc.resp_valid, 1'b0);
    chk("ooo_unit_resp_ready", unit_resp_ready, 2'b01);
    step();
    chk("ooo_hold", acc.resp_valid, 1'b0);
    unit_resp_valid = 2'b11;
    unit_resp_data[63:0] = 64'hA;
    settle();
    chk("ooo_id1", acc.resp_id, 5'd1);
    chk("ooo_data1", acc.resp_data, 64'hA);
    step();
    unit_resp_valid = 2'b10;
    settle();
    chk("ooo_id2", acc.resp_id, 5'd2);
    chk("ooo_data2", acc.resp_data, 64'hB);
    chk("ooo_ready2", unit_resp_ready, 2'b10);
    step();
    unit_resp_valid = '0;
    acc.resp_ready  = 1'b0;
    chk("ooo_outstanding", outstanding, 3'd0);

    // fill to Depth, fifth request refused
    issue_req(5'd5, 2'b01);
    issue_req(5'd6, 2'b10);
    issue_req(5'd7, 2'b01);
    issue_req(5'd8, 2'b10);
    acc.req_valid = 1'b1;
    acc.req_id    = 5'd9;
    settle();
    chk("full_req_ready", acc.req_ready, 1'b0);
    chk("full_unit_valid", unit_req_valid, 2'b00);
    step();
    chk("full_outstanding", outstanding, 3'd4);
    chk("full_stall", stall, 1'b1);

    // pop while full: no push-through, request taken the next cycle
    unit_resp_valid = 2'b01;
    unit_resp_data[63:0] = 64'h55;
    acc.resp_ready = 1'b1;
    settle();
    chk("pt_resp_valid", acc.resp_valid, 1'b1);
    chk("pt_resp_id", acc.resp_id, 5'd5);
    chk("pt_req_ready", acc.req_ready, 1'b0);
    step();
    unit_resp_valid = '0;
    acc.resp_ready  = 1'b0;
    settle();
    chk("pt_outstanding3", outstanding, 3'd3);
    chk("pt_stall", stall, 1'b1);
    chk("pt_req_ready2", acc.req_ready, 1'b1);
    chk("pt_unit_valid", unit_req_valid, 2'b01);
    step();
    acc.req_valid = 1'b0;
    chk("pt_outstanding4", outstanding, 3'd4);
    chk("pt_issue", issue, 1'b1);
    drain_one(1, 5'd6, 64'h66);
    drain_one(0, 5'd7, 64'h77);
    drain_one(1, 5'd8, 64'h88);
    drain_one(0, 5'd9, 64'h99);

    // pointer sits on unit 1; then skip a busy unit 0 and wrap back to 0
    issue_req(5'd10, 2'b10);
    drain_one(1, 5'd10, 64'h1010);
    unit_req_ready = 2'b10;
    issue_req(5'd11, 2'b10);
    chk("skip_issue", issue, 1'b1);
    unit_req_ready = 2'b00;
    acc.req_valid  = 1'b1;
    acc.req_id     = 5'd12;
    settle();
    chk("none_req_ready", acc.req_ready, 1'b0);
    chk("none_unit_valid", unit_req_valid, 2'b00);
    step();
    chk("none_stall", stall, 1'b1);
    chk("none_issue", issue, 1'b0);
    unit_req_ready = 2'b11;
    settle();
    chk("wrap_unit_valid", unit_req_valid, 2'b01);
    step();
    acc.req_valid = 1'b0;

    // asynchronous reset with three in flight
    issue_req(5'd13, 2'b10);
    chk("pre_rst_outstanding", outstanding, 3'd3);
    unit_resp_valid = 2'b10;
    unit_resp_data[127:64] = 64'hCC;
    settle();
    chk("pre_rst_resp_valid", acc.resp_valid, 1'b1);
    chk("pre_rst_resp_id", acc.resp_id, 5'd11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_outstanding", outstanding, 3'd0);
    chk("arst_resp_valid", acc.resp_valid, 1'b0);
    unit_resp_valid = '0;
    step();
    step();
    rst_n = 1'b1;
    issue_req(5'd14, 2'b01);
    chk("post_rst_outstanding", outstanding, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
